// File: rtl/fifo_burst_ctrl_pkg.sv
// ============================================================================
// Module      : fifo_burst_ctrl_pkg
// Description : Shared definitions for the FIFO burst read controller: FSM
//               state encoding, statistics counter width and a saturating
//               increment helper.
// Config      : FIFO_BURST_STATS_EN (consumers only; the package is fixed)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package fifo_burst_ctrl_pkg;

    // Controller states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        FLUSH = 2'd2
    } state_e;

    // Width of the optional statistics counters
    localparam int unsigned CNT_W = 16;

    // Increment that sticks at all-ones instead of wrapping
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/fifo_burst_stats.sv
// ============================================================================
// Module      : fifo_burst_stats
// Description : Two saturating event counters (bursts issued, producer words
//               refused). Cleared by reset and by the controller's FLUSH state.
// Config      : instantiated only when FIFO_BURST_STATS_EN is defined
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fifo_burst_stats
    import fifo_burst_ctrl_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr_i,
    input  logic             burst_inc_i,
    input  logic             drop_inc_i,
    output logic [CNT_W-1:0] burst_cnt_o,
    output logic [CNT_W-1:0] drop_cnt_o
);

    logic [CNT_W-1:0] burst_cnt_q;
    logic [CNT_W-1:0] drop_cnt_q;

    // Count events; a clear wins over an increment in the same cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            burst_cnt_q <= '0;
            drop_cnt_q  <= '0;
        end else if (clr_i) begin
            burst_cnt_q <= '0;
            drop_cnt_q  <= '0;
        end else begin
            if (burst_inc_i) burst_cnt_q <= sat_inc(burst_cnt_q);
            if (drop_inc_i)  drop_cnt_q  <= sat_inc(drop_cnt_q);
        end
    end

    assign burst_cnt_o = burst_cnt_q;
    assign drop_cnt_o  = drop_cnt_q;

endmodule

`default_nettype wire

// File: rtl/fifo_burst_ctrl.sv
// ============================================================================
// Module      : fifo_burst_ctrl
// Description : Burst read controller placed beside a single-clock FIFO.
//               Forwards producer writes, issues fixed-length read bursts to
//               a sink once enough words are buffered (partial bursts while
//               drain is high) and sequences FIFO clearing via sclr.
// Config      : FIFO_BURST_STATS_EN adds burst_cnt / drop_cnt outputs
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fifo_burst_ctrl
    import fifo_burst_ctrl_pkg::*;
#(
    parameter int unsigned DATA_W    = 16,
    parameter int unsigned ADDR_W    = 8,
    parameter int unsigned BURST_LEN = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    // producer side
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    // control
    input  logic              flush,
    input  logic              drain,
    input  logic              sink_ready,
    // FIFO side
    output logic              fifo_wrreq,
    output logic              fifo_rdreq,
    output logic              fifo_sclr,
    output logic [DATA_W-1:0] fifo_data,
    input  logic [DATA_W-1:0] fifo_q,
    input  logic [ADDR_W-1:0] fifo_usedw,
    input  logic              fifo_full,
    input  logic              fifo_empty,
    // sink side
    output logic              burst_start,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last
`ifdef FIFO_BURST_STATS_EN
    ,
    output logic [CNT_W-1:0]  burst_cnt,
    output logic [CNT_W-1:0]  drop_cnt
`endif
);

    localparam int unsigned       LVL_W       = ADDR_W + 1;
    localparam logic [LVL_W-1:0]  c_depth     = LVL_W'(2 ** ADDR_W);
    localparam logic [LVL_W-1:0]  c_burst_len = LVL_W'(BURST_LEN);
    localparam logic [LVL_W-1:0]  c_one       = LVL_W'(1);

    state_e            state_q, state_d;
    logic [LVL_W-1:0]  rd_left_q, rd_left_d;
    logic              flush_pend_q, flush_pend_d;
    logic              ready_en_q;
    logic              rdreq_q;
    logic              sclr_q;
    logic              burst_start_q;
    logic              out_valid_q;
    logic              out_last_q;

    logic [LVL_W-1:0]  w_lvl;
    logic              w_start;

    // usedw wraps to zero when the FIFO is full, so the full flag restores the top count
    assign w_lvl   = fifo_full ? c_depth : {1'b0, fifo_usedw};
    assign w_start = sink_ready & ((w_lvl >= c_burst_len) | (drain & ~fifo_empty));

    // Write path is a pure pass-through gated by in_ready
    assign in_ready   = ready_en_q & ~fifo_full & (state_q != FLUSH) & ~flush_pend_q;
    assign fifo_wrreq = in_valid & in_ready;
    assign fifo_data  = in_data;

    // Producer is held off until the first clock after reset release
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ready_en_q <= 1'b0;
        else        ready_en_q <= 1'b1;
    end

    // Next-state logic: flush beats a burst start; a flush during a burst is deferred
    always_comb begin
        state_d      = state_q;
        rd_left_d    = rd_left_q;
        flush_pend_d = flush_pend_q;
        unique case (state_q)
            IDLE: begin
                if (flush | flush_pend_q) begin
                    state_d = FLUSH;
                end else if (w_start) begin
                    state_d   = READ;
                    rd_left_d = (w_lvl < c_burst_len) ? w_lvl : c_burst_len;
                end
            end
            READ: begin
                rd_left_d = rd_left_q - c_one;
                if (flush) flush_pend_d = 1'b1;
                if (rd_left_q <= c_one) state_d = IDLE;
            end
            FLUSH: begin
                flush_pend_d = 1'b0;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State register plus registered FIFO/sink controls derived from the next state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            rd_left_q     <= '0;
            flush_pend_q  <= 1'b0;
            rdreq_q       <= 1'b0;
            sclr_q        <= 1'b0;
            burst_start_q <= 1'b0;
            out_valid_q   <= 1'b0;
            out_last_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            rd_left_q     <= rd_left_d;
            flush_pend_q  <= flush_pend_d;
            rdreq_q       <= (state_d == READ);
            sclr_q        <= (state_d == FLUSH);
            burst_start_q <= (state_q == IDLE) && (state_d == READ);
            out_valid_q   <= rdreq_q;
            out_last_q    <= rdreq_q && (rd_left_q == c_one);
        end
    end

    assign fifo_rdreq  = rdreq_q;
    assign fifo_sclr   = sclr_q;
    assign burst_start = burst_start_q;
    assign out_valid   = out_valid_q;
    assign out_last    = out_last_q;
    assign out_data    = fifo_q;

`ifdef FIFO_BURST_STATS_EN
    fifo_burst_stats u_stats (
        .clk         (clk),
        .rst_n       (rst_n),
        .clr_i       (state_q == FLUSH),
        .burst_inc_i (burst_start_q),
        .drop_inc_i  (in_valid & ~in_ready & ready_en_q),
        .burst_cnt_o (burst_cnt),
        .drop_cnt_o  (drop_cnt)
    );
`endif

endmodule

`default_nettype wire

// File: tb/tb_fifo_burst_ctrl.sv
// ============================================================================
// Module      : tb_fifo_burst_ctrl
// Description : Self-checking bench for fifo_burst_ctrl with a behavioural
//               FIFO beside the DUT and a queue-based reference model.
// Config      : FIFO_BURST_STATS_EN also checks burst_cnt / drop_cnt
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fifo_burst_ctrl;

    localparam int DATA_W    = 16;
    localparam int ADDR_W    = 8;
    localparam int BURST_LEN = 16;
    localparam int DEPTH     = 256;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [15:0] in_data = '0;
    logic        flush = 1'b0;
    logic        drain = 1'b0;
    logic        sink_ready = 1'b0;
    logic        in_ready, fifo_wrreq, fifo_rdreq, fifo_sclr;
    logic [15:0] fifo_data;
    logic [15:0] fifo_q = '0;
    logic [7:0]  fifo_usedw = '0;
    logic        fifo_full = 1'b0;
    logic        fifo_empty = 1'b1;
    logic        burst_start, out_valid, out_last;
    logic [15:0] out_data;
`ifdef FIFO_BURST_STATS_EN
    logic [15:0] burst_cnt, drop_cnt;
`endif

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    fifo_burst_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .BURST_LEN(BURST_LEN)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .flush(flush), .drain(drain), .sink_ready(sink_ready),
        .fifo_wrreq(fifo_wrreq), .fifo_rdreq(fifo_rdreq), .fifo_sclr(fifo_sclr),
        .fifo_data(fifo_data), .fifo_q(fifo_q), .fifo_usedw(fifo_usedw),
        .fifo_full(fifo_full), .fifo_empty(fifo_empty),
        .burst_start(burst_start), .out_valid(out_valid),
        .out_data(out_data), .out_last(out_last)
`ifdef FIFO_BURST_STATS_EN
        , .burst_cnt(burst_cnt), .drop_cnt(drop_cnt)
`endif
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, got, exp);
        end
    endtask

    // ---------------- behavioural FIFO (normal mode, sync clear) ----------------
    logic [15:0] fq[$];
    logic [15:0] f_tmp;
    int          f_n;
    always @(posedge clk) begin
        if (fifo_sclr) begin
            fq.delete();
        end else begin
            if (fifo_rdreq && fq.size() > 0) begin
                f_tmp = fq.pop_front();
                fifo_q <= f_tmp;
            end
            if (fifo_wrreq && fq.size() < DEPTH) fq.push_back(fifo_data);
        end
        f_n = fq.size();
        fifo_usedw <= 8'(f_n);
        fifo_full  <= (f_n == DEPTH);
        fifo_empty <= (f_n == 0);
    end

    // ---------------- reference model ----------------
    typedef struct packed { logic [15:0] d; logic l; } exp_t;
    exp_t        sb[$];
    logic [15:0] mq[$];
    int          m_left = 0;
    bit          m_flushing = 0, m_pend = 0, m_first = 0, m_rdy_en = 0;
    int          m_nburst = 0, m_drops = 0;
    bit          r_rdy, r_acc, r_first;
    int          r_n;
    exp_t        r_e;

    function automatic bit m_in_ready();
        return m_rdy_en && (mq.size() < DEPTH) && !m_flushing && !m_pend;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_left = 0; m_flushing = 0; m_pend = 0; m_first = 0; m_rdy_en = 0;
            m_nburst = 0; m_drops = 0;
            sb.delete();
        end else begin
            r_rdy   = m_in_ready();
            r_acc   = in_valid && r_rdy;
            r_n     = mq.size();
            r_first = m_first;
            m_first = 0;
            if (m_rdy_en && in_valid && !r_rdy && m_drops < 65535) m_drops++;
            if (r_first && m_nburst < 65535) m_nburst++;
            if (m_flushing) begin
                mq.delete();
                m_flushing = 0; m_pend = 0; m_nburst = 0; m_drops = 0;
            end else if (m_left > 0) begin
                r_e.d = mq.pop_front();
                r_e.l = (m_left == 1);
                sb.push_back(r_e);
                if (flush) m_pend = 1;
                m_left--;
            end else if (flush || m_pend) begin
                m_flushing = 1;
            end else if (sink_ready && (r_n >= BURST_LEN || (drain && r_n > 0))) begin
                m_left  = (r_n < BURST_LEN) ? r_n : BURST_LEN;
                m_first = 1;
            end
            if (r_acc) mq.push_back(in_data);
            m_rdy_en = 1;
        end
    end

    // ---------------- monitor / scoreboard ----------------
    exp_t mon_e;
    int   sclr_seen = 0;
    always @(negedge clk) begin
        if (fifo_sclr) sclr_seen++;
        check("ctrl{ready,rdreq,sclr,start,stray_last}",
              {27'd0, in_ready, fifo_rdreq, fifo_sclr, burst_start, out_last & ~out_valid},
              {27'd0, m_in_ready(), m_left > 0, m_flushing, m_first, 1'b0});
        if (out_valid) begin
            if (sb.size() == 0) begin
                n_cmp++; n_err++;
                $display("FAIL out_unexpected at %0t: got word %0h last %b, expected no output",
                         $time, out_data, out_last);
            end else begin
                mon_e = sb.pop_front();
                check("out_data", {16'd0, out_data}, {16'd0, mon_e.d});
                check("out_last", {31'd0, out_last}, {31'd0, mon_e.l});
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic write_words(input int n, input logic [15:0] base);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = base + 16'(i);
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_quiet(input string name, input int budget);
        int k;
        k = 0;
        repeat (3) @(negedge clk);
        while ((m_left > 0 || m_flushing || m_pend || sb.size() > 0) && k < budget) begin
            @(negedge clk);
            k++;
        end
        repeat (2) @(negedge clk);
        check({name, "_undelivered"}, 32'(sb.size()), 32'd0);
    endtask

    task automatic wait_burst(input string name);
        int k;
        k = 0;
        while (burst_start !== 1'b1 && k < 60) begin
            @(negedge clk);
            k++;
        end
        check({name, "_burst_seen"}, {31'd0, burst_start}, 32'd1);
    endtask

    task automatic check_stats(input string name);
`ifdef FIFO_BURST_STATS_EN
        check({name, "_burst_cnt"}, {16'd0, burst_cnt}, 32'(m_nburst));
        check({name, "_drop_cnt"},  {16'd0, drop_cnt},  32'(m_drops));
`else
        n_cmp = n_cmp + 0;
        if (name.len() == 0) $display("stats disabled");
`endif
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state, with the producer already asserting valid
        in_valid = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_in_ready",    {31'd0, in_ready},    32'd0);
        check("rst_fifo_wrreq",  {31'd0, fifo_wrreq},  32'd0);
        check("rst_fifo_rdreq",  {31'd0, fifo_rdreq},  32'd0);
        check("rst_fifo_sclr",   {31'd0, fifo_sclr},   32'd0);
        check("rst_burst_start", {31'd0, burst_start}, 32'd0);
        check("rst_out_valid",   {31'd0, out_valid},   32'd0);
        check("rst_out_last",    {31'd0, out_last},    32'd0);
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // One full burst of 0..15
        sink_ready = 1'b1;
        write_words(16, 16'd0);
        wait_quiet("burst16", 100);
        check_stats("burst16");

        // Partial burst needs drain
        write_words(5, 16'd100);
        repeat (20) @(negedge clk);
        check("drain_hold_usedw", {24'd0, fifo_usedw}, 32'd5);
        drain = 1'b1;
        wait_quiet("drain5", 100);
        drain = 1'b0;

        // Flush during a burst: burst completes, then one sclr and nothing more
        sink_ready = 1'b0;
        write_words(40, 16'd200);
        sink_ready = 1'b1;
        wait_burst("flush");
        repeat (3) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        wait_quiet("flush", 100);
        check("flush_empty", {31'd0, fifo_empty}, 32'd1);
        check("flush_usedw", {24'd0, fifo_usedw}, 32'd0);
        check_stats("flush");

        // Fill to full with the sink stalled
        sink_ready = 1'b0;
        for (int i = 0; i < 270; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = 16'h1000 + 16'(i);
        end
        @(negedge clk);
        check("full_in_ready", {31'd0, in_ready},  32'd0);
        check("full_flag",     {31'd0, fifo_full}, 32'd1);
        check_stats("full");
        in_valid   = 1'b0;
        sink_ready = 1'b1;
        wait_quiet("full_drain", 800);
        check("full_drain_empty", {31'd0, fifo_empty}, 32'd1);

        // Randomised traffic
        for (int i = 0; i < 2500; i++) begin
            @(negedge clk);
            in_valid   = ($urandom_range(0, 3) != 0);
            in_data    = 16'($urandom);
            sink_ready = ($urandom_range(0, 2) != 0);
            drain      = ($urandom_range(0, 9) < 3);
            flush      = ($urandom_range(0, 199) == 0);
        end
        @(negedge clk);
        in_valid = 1'b0; flush = 1'b0; drain = 1'b1; sink_ready = 1'b1;
        wait_quiet("random", 800);
        check_stats("random");
        drain = 1'b0;

        // Reset in the middle of a burst
        sink_ready = 1'b0;
        write_words(20, 16'h7000);
        sink_ready = 1'b1;
        wait_burst("rstmid");
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        sink_ready = 1'b0;
        #1;
        check("rstmid_rdreq",     {31'd0, fifo_rdreq}, 32'd0);
        check("rstmid_out_valid", {31'd0, out_valid},  32'd0);
        check("rstmid_in_ready",  {31'd0, in_ready},   32'd0);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        sclr_seen = 0;
        repeat (5) @(negedge clk);
        check("rstmid_usedw", {24'd0, fifo_usedw}, 32'd17);
        check("rstmid_no_sclr", 32'(sclr_seen), 32'd0);
        drain = 1'b1; sink_ready = 1'b1;
        wait_quiet("rstmid_rest", 200);
        check("rstmid_empty", {31'd0, fifo_empty}, 32'd1);
        check_stats("rstmid");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
